// File: rtl/reg_access_arbiter.sv
// Two-master round-robin arbiter in front of a single register file port.
// One transaction in flight at a time; reads wait for read_valid or a TIMEOUT-cycle timeout.
module reg_access_arbiter #(
    parameter int TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_write,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_ack,
    output logic        a_rvalid,
    output logic        a_err,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_write,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ack,
    output logic        b_rvalid,
    output logic        b_err,
    output logic [31:0] b_rdata,
    output logic        write,
    output logic [31:0] write_addr,
    output logic [31:0] write_data,
    output logic        read,
    output logic [31:0] read_addr,
    input  logic        read_valid,
    input  logic [31:0] read_data
);

    localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t      state;
    logic        owner_b;
    logic        is_write;
    logic        prio_b;
    logic [3:0]  count;

    logic        grant_b;
    logic        sel_write;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    // B wins only when A is idle or when A was the last master served.
    always_comb begin
        grant_b   = b_req && (!a_req || prio_b);
        sel_write = grant_b ? b_write : a_write;
        sel_addr  = grant_b ? b_addr  : a_addr;
        sel_wdata = grant_b ? b_wdata : a_wdata;
    end

    // Every output is a pulse or a field tied to one state, so each is
    // cleared by default and only set on the edge entering that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner_b    <= 1'b0;
            is_write   <= 1'b0;
            prio_b     <= 1'b0;
            count      <= '0;
            a_ack      <= 1'b0;
            a_rvalid   <= 1'b0;
            a_err      <= 1'b0;
            a_rdata    <= '0;
            b_ack      <= 1'b0;
            b_rvalid   <= 1'b0;
            b_err      <= 1'b0;
            b_rdata    <= '0;
            write      <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            read       <= 1'b0;
            read_addr  <= '0;
        end else begin
            a_ack      <= 1'b0;
            a_rvalid   <= 1'b0;
            a_err      <= 1'b0;
            a_rdata    <= '0;
            b_ack      <= 1'b0;
            b_rvalid   <= 1'b0;
            b_err      <= 1'b0;
            b_rdata    <= '0;
            write      <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            read       <= 1'b0;
            read_addr  <= '0;
            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        owner_b  <= grant_b;
                        is_write <= sel_write;
                        prio_b   <= !grant_b;
                        a_ack    <= !grant_b;
                        b_ack    <= grant_b;
                        state    <= ISSUE;
                        if (sel_write) begin
                            write      <= 1'b1;
                            write_addr <= sel_addr;
                            write_data <= sel_wdata;
                        end else begin
                            read      <= 1'b1;
                            read_addr <= sel_addr;
                        end
                    end
                end
                ISSUE: begin
                    count <= '0;
                    state <= is_write ? IDLE : WAIT;
                end
                WAIT: begin
                    // A response arriving on the timeout cycle still counts as valid.
                    if (read_valid) begin
                        a_rvalid <= !owner_b;
                        b_rvalid <= owner_b;
                        a_rdata  <= owner_b ? 32'h0 : read_data;
                        b_rdata  <= owner_b ? read_data : 32'h0;
                        state    <= IDLE;
                    end else if (count + 4'd1 == TIMEOUT_CNT) begin
                        a_rvalid <= !owner_b;
                        b_rvalid <= owner_b;
                        a_err    <= !owner_b;
                        b_err    <= owner_b;
                        count    <= count + 4'd1;
                        state    <= IDLE;
                    end else begin
                        count <= count + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
